handshake_fifo: RTL and testbench

HANDSHAKE_FIFO -- requirements
Module: handshake_fifo

---
 rtl/handshake_pkg.sv | 10 +
 rtl/handshake_fifo.sv | 66 ++++++
 tb/tb_handshake_fifo.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/handshake_pkg.sv
// handshake_pkg: shared constants and the clog2 helper for handshake_fifo.
package handshake_pkg;
  localparam int def_size  = 32;
  localparam int def_depth = 4;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin end
    return r;
  endfunction
endpackage

// File: rtl/handshake_fifo.sv
// handshake_fifo: strobe/ready FIFO with registered in_ready, almost-full and sticky drop_err.
// Optional synchronous flush port when HANDSHAKE_FIFO_FLUSH_EN is defined.
module handshake_fifo
  import handshake_pkg::*;
#(
  parameter int size        = def_size,
  parameter int depth       = def_depth,
  parameter int afull_level = 3
) (
  input  logic                        clk,
  input  logic                        rstn,
`ifdef HANDSHAKE_FIFO_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic [size-1:0]             in_data,
  input  logic                        in_strobe,
  output logic                        in_ready,
  output logic                        in_afull,
  output logic [size-1:0]             out_data,
  output logic                        out_ready,
  input  logic                        out_strobe,
  output logic [clog2(depth+1)-1:0]   count,
  output logic                        drop_err
);
  localparam int aw = clog2(depth);
  localparam int cw = clog2(depth + 1);
  logic [size-1:0] mem [depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic [cw-1:0] count_next;
  logic push, pop;
  assign push       = in_strobe && in_ready;
  assign pop        = out_strobe && out_ready;
  assign count_next = count + cw'(push) - cw'(pop);
  assign in_afull   = count >= cw'(afull_level);
  assign out_data   = mem[rd_ptr];
  // storage is deliberately left out of reset
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_ready  <= 1'b0;
      out_ready <= 1'b0;
      drop_err  <= 1'b0;
    end
`ifdef HANDSHAKE_FIFO_FLUSH_EN
    else if (flush) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_ready  <= 1'b1;
      out_ready <= 1'b0;
      drop_err  <= 1'b0;
    end
`endif
    else begin
      if (push) wr_ptr <= wr_ptr + aw'(1);
      if (pop) rd_ptr <= rd_ptr + aw'(1);
      count     <= count_next;
      in_ready  <= count_next < cw'(depth);
      out_ready <= count_next != '0;
      if (in_strobe && !in_ready) drop_err <= 1'b1;
    end
endmodule

// File: tb/tb_handshake_fifo.sv
// tb_handshake_fifo: directed and random stimulus against a queue-based reference model.
module tb_handshake_fifo;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
`ifdef HANDSHAKE_FIFO_FLUSH_EN
  localparam bit has_flush = 1'b1;
`else
  localparam bit has_flush = 1'b0;
`endif
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic [31:0] in_data = '0;
  logic in_strobe = 1'b0;
  logic out_strobe = 1'b0;
  logic in_ready, in_afull, out_ready, drop_err;
  logic [31:0] out_data;
  logic [2:0] count;
  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] q[$];
  bit m_ir = 1'b0;
  bit m_drop = 1'b0;

  handshake_fifo #(.size(32), .depth(DEPTH), .afull_level(AF)) dut (
    .clk(clk),
    .rstn(rstn),
`ifdef HANDSHAKE_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .in_data(in_data),
    .in_strobe(in_strobe),
    .in_ready(in_ready),
    .in_afull(in_afull),
    .out_data(out_data),
    .out_ready(out_ready),
    .out_strobe(out_strobe),
    .count(count),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".count"}, 32'(count), 32'(q.size()));
    check({ctx, ".out_ready"}, 32'(out_ready), 32'(q.size() != 0));
    check({ctx, ".in_ready"}, 32'(in_ready), 32'(m_ir));
    check({ctx, ".in_afull"}, 32'(in_afull), 32'(q.size() >= AF));
    check({ctx, ".drop_err"}, 32'(drop_err), 32'(m_drop));
    if (q.size() != 0) check({ctx, ".out_data"}, out_data, q[0]);
  endtask

  task automatic model_reset();
    q.delete();
    m_ir = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic step(input string ctx, input logic s, input logic [31:0] d, input logic o, input logic f);
    bit do_push, do_pop;
    in_strobe = s;
    in_data = d;
    out_strobe = o;
    flush = f;
    @(posedge clk);
    if (f && has_flush) begin
      q.delete();
      m_drop = 1'b0;
      m_ir = 1'b1;
    end else begin
      do_pop = o && q.size() != 0;
      do_push = s && m_ir;
      if (s && !m_ir) m_drop = 1'b1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
      m_ir = q.size() < DEPTH;
    end
    @(negedge clk);
    in_strobe = 1'b0;
    out_strobe = 1'b0;
    flush = 1'b0;
    compare_all(ctx);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    in_strobe = 1'b0;
    out_strobe = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    model_reset();
    compare_all("reset");
    rstn = 1'b1;
  endtask

  initial begin
    do_reset();
    step("first_edge", 1'b1, 32'hA5, 1'b0, 1'b0);
    step("idle", 1'b0, 32'h0, 1'b0, 1'b0);
    do_reset();
    step("rel", 1'b0, 32'h0, 1'b0, 1'b0);
    step("fill1", 1'b1, 32'h11, 1'b0, 1'b0);
    step("fill2", 1'b1, 32'h22, 1'b0, 1'b0);
    step("fill3", 1'b1, 32'h33, 1'b0, 1'b0);
    step("fill4", 1'b1, 32'h44, 1'b0, 1'b0);
    step("fill5", 1'b1, 32'h55, 1'b0, 1'b0);
    step("full_pp", 1'b1, 32'h55, 1'b1, 1'b0);
    step("after_full", 1'b0, 32'h0, 1'b0, 1'b0);
    do_reset();
    step("rel", 1'b0, 32'h0, 1'b0, 1'b0);
    step("pre1", 1'b1, 32'hF0, 1'b0, 1'b0);
    step("pre2", 1'b1, 32'hF1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("stream", 1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
    do_reset();
    step("rel", 1'b0, 32'h0, 1'b0, 1'b0);
    step("empty_pp", 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    step("hold", 1'b0, 32'h0, 1'b0, 1'b0);
    if (has_flush) begin
      step("fp1", 1'b1, 32'h1, 1'b0, 1'b0);
      step("fp2", 1'b1, 32'h2, 1'b0, 1'b0);
      step("fp3", 1'b1, 32'h3, 1'b0, 1'b0);
      step("flush", 1'b1, 32'h77, 1'b0, 1'b1);
    end
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           has_flush && ($urandom_range(0, 31) == 0));
      if (i == 200) begin
        #2 rstn = 1'b0;
        #1 model_reset();
        compare_all("async_rst");
        @(negedge clk);
        rstn = 1'b1;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
